// File: rtl/note_sequencer_pkg.sv
// Shared types and constants for the note sequencer: FSM states, field widths
// and the song-table entry layout.
package note_sequencer_pkg;

  localparam int N_ENTRIES = 16;
  localparam int IDX_W     = 4;
  localparam int NOTE_W    = 4;
  localparam int DUR_W     = 8;

  localparam logic [DUR_W-1:0] DUR_END = '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLAY = 2'd2
  } state_t;

  typedef struct packed {
    logic [NOTE_W-1:0] note;
    logic [DUR_W-1:0]  dur;
  } entry_t;

endpackage

// File: rtl/note_table.sv
// Song table: DEPTH x {note, dur} register file, one write port, one
// asynchronous read port, cleared by the asynchronous reset.
module note_table
  import note_sequencer_pkg::*;
#(
  parameter int DEPTH = N_ENTRIES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  entry_t           wr_data,
  input  logic [IDX_W-1:0] rd_addr,
  output entry_t           rd_data,
  output entry_t           head_data
);

  entry_t mem [DEPTH];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      entry_t entry_reg;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          entry_reg <= '0;
        end else if (wr_en && (wr_addr == IDX_W'(gi))) begin
          entry_reg <= wr_data;
        end
      end

      assign mem[gi] = entry_reg;
    end
  endgenerate

  assign rd_data = mem[rd_addr];
  // Entry 0 is always visible so a loop restart can be loaded in the same
  // cycle the end of the song is detected through the indexed port.
  assign head_data = mem[0];

endmodule

// File: rtl/note_sequencer.sv
// Note sequencer: steps through the song table, loading each entry's duration
// into an external down counter and holding the entry's pitch while it plays.
module note_sequencer
  import note_sequencer_pkg::*;
#(
  parameter int N_ENTRIES = note_sequencer_pkg::N_ENTRIES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              loop,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_addr,
  input  logic [NOTE_W-1:0] wr_note,
  input  logic [DUR_W-1:0]  wr_dur,
  input  logic              cnt_done,
  output logic              cnt_load,
  output logic [DUR_W-1:0]  cnt_in,
  output logic [NOTE_W-1:0] note,
  output logic [IDX_W-1:0]  idx,
  output logic              playing,
  output logic              song_done
);

  state_t           state_reg;
  entry_t           next_entry;
  entry_t           head_entry;
  logic [IDX_W-1:0] next_idx;
  logic             song_end;

  assign next_idx = idx + IDX_W'(1);
  assign song_end = (idx == IDX_W'(N_ENTRIES - 1)) || (next_entry.dur == DUR_END);

  note_table #(
    .DEPTH (N_ENTRIES)
  ) u_table (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   ({wr_note, wr_dur}),
    .rd_addr   (next_idx),
    .rd_data   (next_entry),
    .head_data (head_entry)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      idx       <= '0;
      note      <= '0;
      cnt_in    <= '0;
      cnt_load  <= 1'b0;
      playing   <= 1'b0;
      song_done <= 1'b0;
    end else begin
      cnt_load  <= 1'b0;
      song_done <= 1'b0;
      if (stop) begin
        state_reg <= IDLE;
        idx       <= '0;
        note      <= '0;
        cnt_in    <= '0;
        playing   <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (start) begin
              if (head_entry.dur == DUR_END) begin
                song_done <= 1'b1;
              end else begin
                state_reg <= LOAD;
                idx       <= '0;
                note      <= head_entry.note;
                cnt_in    <= head_entry.dur;
                cnt_load  <= 1'b1;
                playing   <= 1'b1;
              end
            end
          end
          // The counter still shows its previous value here, so cnt_done is not looked at.
          LOAD: state_reg <= PLAY;
          PLAY: begin
            if (cnt_done) begin
              if (!song_end) begin
                state_reg <= LOAD;
                idx       <= next_idx;
                note      <= next_entry.note;
                cnt_in    <= next_entry.dur;
                cnt_load  <= 1'b1;
              end else if (loop) begin
                state_reg <= LOAD;
                idx       <= '0;
                note      <= head_entry.note;
                cnt_in    <= head_entry.dur;
                cnt_load  <= 1'b1;
              end else begin
                state_reg <= IDLE;
                idx       <= '0;
                note      <= '0;
                cnt_in    <= '0;
                playing   <= 1'b0;
                song_done <= 1'b1;
              end
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer: a behavioural down counter is attached
// and every cycle is compared against a timeline expanded from the song table.
module tb_note_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic       loop;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [3:0] wr_note;
  logic [7:0] wr_dur;
  logic       cnt_done;
  logic       cnt_load;
  logic [7:0] cnt_in;
  logic [3:0] note;
  logic [3:0] idx;
  logic       playing;
  logic       song_done;

  int pass_cnt  = 0;
  int total_cnt = 0;

  note_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .loop      (loop),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_note   (wr_note),
    .wr_dur    (wr_dur),
    .cnt_done  (cnt_done),
    .cnt_load  (cnt_load),
    .cnt_in    (cnt_in),
    .note      (note),
    .idx       (idx),
    .playing   (playing),
    .song_done (song_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream 8-bit down counter
  logic [7:0] cnt;
  always @(posedge clk or negedge rst) begin
    if (!rst)            cnt <= 8'd0;
    else if (cnt_load)   cnt <= cnt_in;
    else if (cnt != 0)   cnt <= cnt - 8'd1;
  end
  assign cnt_done = (cnt == 8'd0);

  // Observed vector: {playing, cnt_load, song_done, idx, note, cnt_in}
  logic [18:0] obs;
  assign obs = {playing, cnt_load, song_done, idx, note, cnt_in};

  // Reference song table and expected per-cycle timeline
  logic [3:0] m_note [16];
  logic [7:0] m_dur  [16];

  typedef struct packed {
    logic        lp;
    logic [18:0] exp;
  } step_t;
  step_t tl [$];

  function automatic logic [18:0] pk(input logic pl, input logic ld, input logic sd,
                                     input logic [3:0] i, input logic [3:0] n,
                                     input logic [7:0] c);
    return {pl, ld, sd, i, n, c};
  endfunction

  // Each entry: one load cycle then dur+1 play cycles; the song stops at the
  // first zero duration or after entry 15, then one song_done cycle follows.
  function automatic void build(input int passes);
    step_t s;
    tl.delete();
    for (int p = 0; p < passes; p++) begin
      for (int k = 0; k < 16 && m_dur[k] != 8'd0; k++) begin
        s.lp  = (p < passes - 1);
        s.exp = pk(1'b1, 1'b1, 1'b0, 4'(k), m_note[k], m_dur[k]);
        tl.push_back(s);
        for (int c = 0; c <= int'(m_dur[k]); c++) begin
          s.exp = pk(1'b1, 1'b0, 1'b0, 4'(k), m_note[k], m_dur[k]);
          tl.push_back(s);
        end
      end
    end
    s.lp  = 1'b0;
    s.exp = pk(1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 8'd0);
    tl.push_back(s);
  endfunction

  task automatic write_entry(input int a, input logic [3:0] n, input logic [7:0] d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = 4'(a);
    wr_note = n;
    wr_dur  = d;
    @(negedge clk);
    wr_en = 1'b0;
    m_note[a] = n;
    m_dur[a]  = d;
  endtask

  task automatic check_idle(input string name, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      total_cnt++;
      if (obs !== 19'd0)
        $display("FAIL %s idle cycle %0d: got %h, expected %h", name, c, obs, 19'd0);
      else
        pass_cnt++;
    end
  endtask

  // Plays the current table; optional mid-song stop and mid-song write to entry 0.
  task automatic run_song(input string name, input int passes, input int stop_at,
                          input bit stop_start, input int wr_at);
    logic [3:0] nn;
    logic [7:0] nd;
    build(passes);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < tl.size(); i++) begin
      if (i > 0) @(negedge clk);
      wr_en = 1'b0;
      stop  = 1'b0;
      total_cnt++;
      if (obs !== tl[i].exp)
        $display("FAIL %s cycle %0d: got %h, expected %h", name, i, obs, tl[i].exp);
      else
        pass_cnt++;
      loop = tl[i].lp;
      if (i == wr_at) begin
        nn = 4'($urandom_range(15, 0));
        nd = 8'($urandom_range(4, 1));
        wr_en = 1'b1; wr_addr = 4'd0; wr_note = nn; wr_dur = nd;
        m_note[0] = nn; m_dur[0] = nd;
      end
      if (i == stop_at) begin
        stop  = 1'b1;
        start = stop_start;
        break;
      end
    end
    @(negedge clk);
    wr_en = 1'b0; stop = 1'b0; start = 1'b0; loop = 1'b0;
    total_cnt++;
    if (obs !== 19'd0)
      $display("FAIL %s after end: got %h, expected %h", name, obs, 19'd0);
    else
      pass_cnt++;
    check_idle(name, 2);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total_cnt++;
      if (obs !== 19'd0)
        $display("FAIL reset cycle %0d: got %h, expected %h", c, obs, 19'd0);
      else
        pass_cnt++;
    end
    for (int k = 0; k < 16; k++) begin
      m_note[k] = 4'd0;
      m_dur[k]  = 8'd0;
    end
    rst = 1'b1;
  endtask

  task automatic test_single_entry();
    write_entry(0, 4'd5, 8'd3);
    write_entry(1, 4'($urandom_range(15, 0)), 8'd0);
    run_song("single_entry", 1, -1, 1'b0, -1);
  endtask

  task automatic test_three_entry();
    write_entry(0, 4'($urandom_range(15, 0)), 8'd2);
    write_entry(1, 4'($urandom_range(15, 0)), 8'hFF);
    write_entry(2, 4'($urandom_range(15, 0)), 8'd1);
    write_entry(3, 4'd0, 8'd0);
    run_song("three_entry_wr_hold", 1, -1, 1'b0, 1);
  endtask

  task automatic test_loop();
    write_entry(0, 4'($urandom_range(15, 1)), 8'($urandom_range(4, 1)));
    write_entry(1, 4'($urandom_range(15, 1)), 8'($urandom_range(4, 1)));
    write_entry(2, 4'd0, 8'd0);
    run_song("loop", 3, -1, 1'b0, -1);
  endtask

  task automatic test_full_table();
    for (int k = 0; k < 16; k++) write_entry(k, 4'($urandom_range(15, 0)), 8'd1);
    run_song("full_table", 1, -1, 1'b0, -1);
  endtask

  task automatic test_random_songs();
    int len;
    for (int s = 0; s < 6; s++) begin
      len = $urandom_range(16, 1);
      for (int k = 0; k < len; k++)
        write_entry(k, 4'($urandom_range(15, 0)), 8'($urandom_range(8, 1)));
      if (len < 16) write_entry(len, 4'($urandom_range(15, 0)), 8'd0);
      run_song($sformatf("random_song%0d", s), (s % 2) + 1, -1, 1'b0, -1);
    end
  endtask

  task automatic test_stop();
    for (int k = 0; k < 3; k++)
      write_entry(k, 4'($urandom_range(15, 1)), 8'($urandom_range(6, 3)));
    write_entry(3, 4'd0, 8'd0);
    run_song("stop_mid_play", 1, $urandom_range(4, 1), 1'b0, -1);
    run_song("stop_with_start", 1, 2, 1'b1, -1);
    @(negedge clk);
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    total_cnt++;
    if (obs !== 19'd0)
      $display("FAIL stop_start_idle: got %h, expected %h", obs, 19'd0);
    else
      pass_cnt++;
    run_song("restart_after_stop", 1, -1, 1'b0, -1);
  endtask

  task automatic test_async_reset();
    write_entry(0, 4'($urandom_range(15, 1)), 8'd6);
    write_entry(1, 4'($urandom_range(15, 1)), 8'd5);
    write_entry(2, 4'd0, 8'd0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (playing !== 1'b1)
      $display("FAIL async_reset pre: playing got %b, expected 1", playing);
    else
      pass_cnt++;
    rst = 1'b0;
    #1;
    total_cnt++;
    if (obs !== 19'd0)
      $display("FAIL async_reset immediate: got %h, expected %h", obs, 19'd0);
    else
      pass_cnt++;
    for (int k = 0; k < 16; k++) begin
      m_note[k] = 4'd0;
      m_dur[k]  = 8'd0;
    end
    @(negedge clk);
    rst = 1'b1;
    run_song("empty_song", 1, -1, 1'b0, -1);
    write_entry(0, 4'($urandom_range(15, 1)), 8'd3);
    run_song("table_cleared", 1, -1, 1'b0, -1);
  endtask

  initial begin
    start = 1'b0; stop = 1'b0; loop = 1'b0;
    wr_en = 1'b0; wr_addr = 4'd0; wr_note = 4'd0; wr_dur = 8'd0;
    test_reset();
    test_single_entry();
    test_three_entry();
    test_loop();
    test_full_table();
    test_random_songs();
    test_stop();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
